// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches over a req/ack handshake and
// applies the control unit's PC-update command with branch/jump resolution.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_fetch_start,
  input  logic            i_pc_update,
  input  logic            i_pc_src,
  input  logic [XLEN-1:0] i_imm,
  input  logic [3:0]      i_alu_flags,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instr,
  output logic [6:0]      o_opcode,
  output logic            o_instr_valid,
  output logic            o_misalign_err
);

  typedef enum logic [1:0] {StIdle, StReq, StValid} state_e;

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  state_e          r_state;
  state_e          w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_misalign_err;

  logic [2:0]      w_funct3;
  logic            w_zero;
  logic            w_lt;
  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic            w_misalign;
  logic            w_commit;
  logic            w_unused;

  assign w_unused = i_alu_flags[3];
  assign w_funct3 = r_instr[14:12];
  assign w_zero   = i_alu_flags[0];
  // Signed less-than from the subtraction's sign and overflow flags.
  assign w_lt     = i_alu_flags[1] ^ i_alu_flags[2];

  always_comb begin
    w_taken = 1'b0;
    case (r_instr[6:0])
      OpBranch: begin
        case (w_funct3)
          3'b000:  w_taken = w_zero;
          3'b001:  w_taken = ~w_zero;
          3'b100:  w_taken = w_lt;
          3'b101:  w_taken = ~w_lt;
          default: w_taken = 1'b0;
        endcase
      end
      OpJal:   w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_target   = (i_pc_src && w_taken) ? r_pc + i_imm : r_pc + XLEN'(4);
  assign w_misalign = |w_target[1:0];
  assign w_commit   = (r_state == StValid) && i_pc_update;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_fetch_start) w_state_next = StReq;
      StReq:   if (i_imem_ack) w_state_next = StValid;
      StValid: if (i_pc_update) w_state_next = i_fetch_start ? StReq : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_pc           <= RESET_PC;
      r_instr        <= '0;
      r_misalign_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StReq && i_imem_ack) begin
        r_instr <= i_imem_rdata;
      end
      // A misaligned target leaves the PC alone and latches the sticky error.
      if (w_commit) begin
        if (w_misalign) begin
          r_misalign_err <= 1'b1;
        end else begin
          r_pc <= w_target;
        end
      end
    end
  end

  assign o_imem_req     = (r_state == StReq);
  assign o_imem_addr    = r_pc;
  assign o_pc           = r_pc;
  assign o_instr        = r_instr;
  assign o_opcode       = r_instr[6:0];
  assign o_instr_valid  = (r_state == StValid);
  assign o_misalign_err = r_misalign_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed cases followed by random
// fetch/update traffic checked against a reference model of the PC rules.
module tb_instr_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_start, pc_update, pc_src;
  logic [31:0] imm;
  logic [3:0]  alu_flags;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc, instr;
  logic [6:0]  opcode;
  logic        instr_valid, misalign_err;

  instr_fetch_unit #(
    .XLEN    (32),
    .RESET_PC(ResetPc)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_fetch_start (fetch_start),
    .i_pc_update   (pc_update),
    .i_pc_src      (pc_src),
    .i_imm         (imm),
    .i_alu_flags   (alu_flags),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .i_imem_rdata  (imem_rdata),
    .o_pc          (pc),
    .o_instr       (instr),
    .o_opcode      (opcode),
    .o_instr_valid (instr_valid),
    .o_misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        err;
  } pc_exp_t;

  logic [31:0] q_addr[$];
  logic [31:0] q_instr[$];
  pc_exp_t     q_pc[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: branch/jump resolution straight from the ISA rules.
  function automatic logic [31:0] ref_target(input logic [31:0] cur_pc, input logic [31:0] ins,
                                             input logic src, input logic [31:0] off,
                                             input logic [3:0] fl);
    bit taken = 0;
    bit lt    = fl[1] ^ fl[2];
    if (ins[6:0] == 7'h63) begin
      case (ins[14:12])
        3'd0:    taken = fl[0];
        3'd1:    taken = !fl[0];
        3'd4:    taken = lt;
        3'd5:    taken = !lt;
        default: taken = 0;
      endcase
    end else if (ins[6:0] == 7'h6F) begin
      taken = 1;
    end
    return (src && taken) ? cur_pc + off : cur_pc + 32'd4;
  endfunction

  // Monitor: handshakes, IR loads and VALID exits each pop one expectation.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (imem_req && imem_ack) begin
      if (q_addr.size() == 0) chk("unexpected_handshake", 32'd1, 32'd0);
      else chk("fetch_addr", imem_addr, q_addr.pop_front());
    end
    if (instr_valid && !prev_valid) begin
      if (q_instr.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        logic [31:0] e;
        e = q_instr.pop_front();
        chk("ir", instr, e);
        chk("opcode", {25'd0, opcode}, {25'd0, e[6:0]});
      end
    end
    if (!instr_valid && prev_valid) begin
      if (q_pc.size() == 0) chk("unexpected_exit", 32'd1, 32'd0);
      else begin
        pc_exp_t e;
        e = q_pc.pop_front();
        chk("pc", pc, e.pc);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.err});
      end
    end
    prev_valid = instr_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input bit started, input int waits, input logic [31:0] rdata,
                          input bit noise);
    if (!started) begin
      fetch_start = 1'b1;
      q_addr.push_back(m_pc);
      tick();
      fetch_start = 1'b0;
    end
    for (int i = 0; i < waits; i++) begin
      chk("req_wait", {31'd0, imem_req}, 32'd1);
      chk("addr_wait", imem_addr, m_pc);
      pc_update   = noise ? 1'($urandom) : 1'b0;
      fetch_start = noise ? 1'($urandom) : 1'b0;
      tick();
    end
    pc_update   = 1'b0;
    fetch_start = 1'b0;
    chk("req_ack", {31'd0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    q_instr.push_back(rdata);
    m_instr = rdata;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic do_update(input logic src, input logic [31:0] off, input logic [3:0] fl,
                           input bit fs);
    logic [31:0] tgt;
    pc_exp_t e;
    tgt = ref_target(m_pc, m_instr, src, off, fl);
    if (tgt[1:0] != 2'b00) m_err = 1'b1;
    else m_pc = tgt;
    e.pc  = m_pc;
    e.err = m_err;
    q_pc.push_back(e);
    pc_update   = 1'b1;
    pc_src      = src;
    imm         = off;
    alu_flags   = fl;
    fetch_start = fs;
    if (fs) q_addr.push_back(m_pc);
    tick();
    pc_update   = 1'b0;
    fetch_start = 1'b0;
    pc_src      = $urandom;
    imm         = $urandom;
    if (fs) begin
      chk("combined_req", {31'd0, imem_req}, 32'd1);
      chk("combined_addr", imem_addr, m_pc);
    end
  endtask

  initial begin
    rst_n = 1'b0; fetch_start = 1'b0; pc_update = 1'b0; pc_src = 1'b0;
    imm = '0; alu_flags = '0; imem_ack = 1'b0; imem_rdata = '0;
    m_pc = ResetPc; m_err = 1'b0; m_instr = '0;
    tick(); tick();
    chk("rst_pc", pc, ResetPc);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic fetch, 3 wait cycles, then sequential update.
    do_fetch(0, 3, 32'h00A0_0093, 0);
    chk("basic_valid", {31'd0, instr_valid}, 32'd1);
    chk("basic_opcode", {25'd0, opcode}, 32'h13);
    do_update(0, 32'd0, 4'b0000, 0);
    chk("basic_pc", pc, 32'h104);

    // BEQ taken then not taken.
    do_fetch(0, 0, 32'h0000_0463, 0);
    do_update(1, 32'd8, 4'b0001, 0);
    chk("beq_taken_pc", pc, 32'h10C);
    do_fetch(0, 1, 32'h0000_0463, 0);
    do_update(1, 32'd8, 4'b0000, 0);
    chk("beq_not_taken_pc", pc, 32'h110);

    // BLT: MSB^overflow decides.
    do_fetch(0, 2, 32'h0000_4463, 0);
    do_update(1, 32'd16, 4'b0110, 0);
    chk("blt_not_taken_pc", pc, 32'h114);
    do_fetch(0, 0, 32'h0000_4463, 0);
    do_update(1, 32'd16, 4'b0010, 0);
    chk("blt_taken_pc", pc, 32'h124);

    // Jump to the top of the address space, then wrap.
    do_fetch(0, 0, 32'h0000_006F, 0);
    do_update(1, 32'hFFFF_FFFC - m_pc, 4'b0000, 0);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    do_fetch(0, 1, 32'h0000_0013, 0);
    do_update(0, 32'd0, 4'b0000, 0);
    chk("wrap_pc", pc, 32'h0);

    // Misaligned jal: PC held, error sticky.
    do_fetch(0, 0, 32'h0000_006F, 0);
    do_update(1, 32'd6, 4'b0000, 0);
    chk("misalign_pc", pc, 32'h0);
    chk("misalign_set", {31'd0, misalign_err}, 32'd1);
    do_fetch(0, 1, 32'h0000_0013, 0);
    do_update(0, 32'd0, 4'b0000, 0);
    chk("misalign_sticky", {31'd0, misalign_err}, 32'd1);

    // Combined update + fetch_start in VALID.
    do_fetch(0, 0, 32'h0000_0013, 0);
    do_update(0, 32'd0, 4'b0000, 1);
    do_fetch(1, 1, 32'h0000_0013, 0);
    do_update(0, 32'd0, 4'b0000, 0);

    // Reset during REQ; a late ack must be ignored.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_pc", pc, ResetPc);
    chk("midrst_err", {31'd0, misalign_err}, 32'd0);
    m_pc = ResetPc; m_err = 1'b0;

    // Random traffic with ignored-input noise.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] rd;
      logic [6:0]  op;
      int          sel;
      bit          comb;
      sel = $urandom_range(0, 3);
      op  = (sel < 2) ? 7'h63 : (sel == 2) ? 7'h6F : 7'h13;
      rd  = $urandom;
      rd[6:0] = op;
      if ($urandom_range(0, 3) == 0) begin
        imem_ack = 1'b1;
        pc_update = 1'b1;
        tick();
        imem_ack = 1'b0;
        pc_update = 1'b0;
      end
      do_fetch(0, $urandom_range(0, 3), rd, 1);
      if ($urandom_range(0, 2) == 0) begin
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
      end
      comb = ($urandom_range(0, 2) == 0);
      do_update(1'($urandom), 32'(($urandom_range(0, 63) - 32) * 4), 4'($urandom), comb);
      if (comb) do_fetch(1, $urandom_range(0, 2), 32'h0000_0013, 0);
      if (comb) do_update(0, 32'd0, 4'b0000, 0);
    end

    tick(); tick();
    chk("q_addr_empty", q_addr.size(), 32'd0);
    chk("q_instr_empty", q_instr.size(), 32'd0);
    chk("q_pc_empty", q_pc.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Datapath-side counterpart of the multi-cycle control unit `uc`.
- Owns the PC and the instruction register (IR), and fetches instructions from instruction memory over a req/ack handshake.
- Presents `opcode` to the control unit.
- Applies the control unit's PC-update command, using `pc_src` and the ALU flags to resolve branch/jump targets.

Parameters:
- XLEN, 32, width of PC, instruction and immediate.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- fetch_start  in  1  one-cycle pulse from the control unit (fetch state): start an instruction fetch.
- pc_update  in  1  one-cycle pulse from the control unit: commit the next PC.
- pc_src  in  1  0: next PC = PC+4; 1: PC-relative target when the condition holds.
- imm  in  XLEN  sign-extended B/J immediate from the immediate generator.
- alu_flags  in  4  [0] zero, [1] MSB, [2] overflow, [3] unused.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  XLEN  fetch address, equal to the PC.
- imem_ack  in  1  instruction memory has data this cycle.
- imem_rdata  in  XLEN  instruction word, valid when imem_ack=1.
- pc  out  XLEN  current PC.
- instr  out  XLEN  IR contents.
- opcode  out  7  instr[6:0], to the control unit.
- instr_valid  out  1  IR holds the instruction for the current PC.
- misalign_err  out  1  sticky: a computed target had bits [1:0] != 0.

Behaviour:
- Reset, when rst_n=0 at a clock edge:
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, misalign_err=0, state=IDLE.
  - A reset arriving mid-REQ drops imem_req the following cycle. A late imem_ack is ignored.
- States:
  - IDLE: imem_req=0, instr_valid=0. fetch_start=1 -> REQ.
  - REQ: imem_req=1, imem_addr=pc. If imem_ack=1 in the same cycle, IR<=imem_rdata and go to VALID; otherwise stay in REQ, holding req and addr stable. An ack in the first REQ cycle is legal, giving 1-cycle latency.
  - VALID: instr_valid=1, IR stable. pc_update=1 -> compute next PC (below) -> IDLE. If fetch_start=1 in the same cycle, go directly to REQ with the new PC; imem_addr shows the new PC in the first REQ cycle.
- Ignored inputs:
  - fetch_start in REQ or VALID is ignored, except the combined case above.
  - pc_update in IDLE or REQ is ignored; PC is unchanged.
  - imem_ack outside REQ is ignored.
- Branch condition, with funct3=instr[14:12] and lt = MSB ^ overflow:
  - opcode 1100011 (branch): 000 taken=zero; 001 taken=!zero; 100 taken=lt; 101 taken=!lt; any other funct3 taken=0.
  - opcode 1101111 (jal): taken=1.
  - Any other opcode: taken=0.
- Next PC:
  - target = pc_src && taken ? pc+imm : pc+4.
  - Addition is modulo 2^XLEN; wrap-around is silent (pc=FFFF_FFFC, +4 -> 0000_0000).
- Misalignment:
  - If target[1:0] != 0, PC is not updated, misalign_err<=1, and the state still moves to IDLE.
  - misalign_err stays set until reset.
- Outputs are registered state, except `opcode` (a slice of IR) and `imem_addr` (equal to pc).

Test Plan:
- Reset: rst_n=0 for 2 cycles with RESET_PC=0x100 -> pc=0x100, imem_req=0, instr_valid=0, misalign_err=0.
- Basic fetch: fetch_start, ack after 3 wait cycles with rdata=0x00A00093 -> imem_req high for 4 cycles at addr 0x100, then instr_valid=1, opcode=0x13. Then pc_update with pc_src=0 -> pc=0x104.
- BEQ taken: IR=0x00000463 (funct3=000), zero=1, pc_src=1, imm=8 at pc=0x104 -> pc=0x10C. Repeat with zero=0 -> pc=0x108.
- BLT: funct3=100, MSB=1, overflow=1 -> not taken (pc+4). MSB=1, overflow=0 -> taken (pc+imm).
- Wrap and misalignment:
  - pc=0xFFFF_FFFC, pc_src=0 -> pc=0.
  - jal with imm=6 -> pc unchanged, misalign_err=1, and it stays 1 after further fetches.
- Simultaneous and reset mid-operation:
  - pc_update+fetch_start together in VALID -> next cycle REQ with imem_addr equal to the new PC.
  - rst_n=0 during REQ -> imem_req=0 next cycle, and a later ack does not raise instr_valid.
